// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller.
// Contents:
//   - MDOp class encodings (MD_NONE .. MD_DIVU)
//   - move-to / move-from encodings (MT_HI, MT_LO, MF_HI, MF_LO)
//   - issue FSM state type
//   - default unit latency and the progress counter width / ceiling
//   - md_op_valid(): true for a real mult/div class (1..4); 5-7 count as none
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;

  localparam logic [1:0] MT_HI = 2'b01;
  localparam logic [1:0] MT_LO = 2'b10;
  localparam logic [1:0] MF_HI = 2'b01;
  localparam logic [1:0] MF_LO = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } md_state_e;

  localparam int         MD_LAT_DEFAULT = 5;
  localparam int         CNT_W          = 4;
  localparam logic [3:0] CNT_MAX        = 4'd15;

  function automatic logic md_op_valid(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_hazard_unit.sv
// Combinational D-stage hazard detection for the mult/div unit.
// A D-stage instruction is mult/div class when it is a mult/div op, a
// move-to-Hi/Lo or a move-from-Hi/Lo. Such an instruction stalls while an
// operation is being issued, is tracked as running, or the unit reports busy.
// Ports:
//   MDOp_D, MTOp_D, MFOp_D  in   D-stage instruction class fields
//   start                   in   issue pulse this cycle (busy rises a cycle later)
//   run_active              in   op tracked in flight and not completing this cycle
//   busy                    in   unit busy flag (already masked by the caller)
//   Stall_MD                out  stall request for D
module md_hazard_unit
  import md_pkg::*;
(
  input  logic [2:0] MDOp_D,
  input  logic [1:0] MTOp_D,
  input  logic [1:0] MFOp_D,
  input  logic       start,
  input  logic       run_active,
  input  logic       busy,
  output logic       Stall_MD
);

  logic md_class_d;

  always_comb begin
    md_class_d = md_op_valid(MDOp_D) | (MTOp_D != 2'b00) | (MFOp_D != 2'b00);
    Stall_MD   = md_class_d & (start | run_active | busy);
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue and hazard controller for the multiply/divide unit.
// Issues a one-cycle start pulse with the op code from the E-stage
// instruction (suppressed on Flush), passes move-to codes through when no
// mult/div op competes, tracks the op in flight with an IDLE/RUN FSM and a
// saturating progress counter, and stalls D on mult/div-class conflicts.
// Optional build macro MD_TIMEOUT_EN: abandon an op whose busy outlives
// MD_LAT+TIMEOUT_SLACK RUN cycles, flagging md_err and releasing the stall.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   MDOp_E, MTOp_E    E-stage mult/div class and move-to code
//   MDOp_D, MTOp_D,
//   MFOp_D            D-stage class fields for hazard detection
//   Flush             E-stage instruction killed this cycle
//   busy              busy flag from the mult/div unit
//   start, MDOp, MTOp issue controls to the unit
//   Stall_MD          stall request for D
//   md_done           one-cycle pulse, Hi/Lo final
//   md_err            sticky error flag
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MD_LAT        = MD_LAT_DEFAULT,
  parameter int TIMEOUT_SLACK = 4
)(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] MDOp_E,
  input  logic [1:0] MTOp_E,
  input  logic [2:0] MDOp_D,
  input  logic [1:0] MTOp_D,
  input  logic [1:0] MFOp_D,
  input  logic       Flush,
  input  logic       busy,
  output logic       start,
  output logic [2:0] MDOp,
  output logic [1:0] MTOp,
  output logic       Stall_MD,
  output logic       md_done,
  output logic       md_err
);

  // The counter must be able to reach the timeout limit before saturating.
  if (MD_LAT < 1 || MD_LAT + TIMEOUT_SLACK > 15) begin : g_cfg_err
    $error("md_issue_ctrl: MD_LAT+TIMEOUT_SLACK must fit the 4-bit counter");
  end

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             md_err_r;
  logic             md_vld_e;
  logic             in_run;
  logic             timeout;
  logic             done;
  logic             run_active;
  logic             busy_eff;
  logic             err_set;

`ifdef MD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(MD_LAT + TIMEOUT_SLACK);
  // After a timeout the unit may keep busy stuck high; ignore it until it
  // finally drops so the stall stays released.
  logic busy_ignore;
`endif

  always_comb begin
    md_vld_e = md_op_valid(MDOp_E);
    in_run   = (state == ST_RUN);

    start = (state == ST_IDLE) & md_vld_e & ~Flush;
    MDOp  = start ? MDOp_E : MD_NONE;
    MTOp  = ((state == ST_IDLE) & ~Flush & ~md_vld_e) ? MTOp_E : 2'b00;

`ifdef MD_TIMEOUT_EN
    timeout  = in_run & busy & (cnt >= TO_LIMIT);
    busy_eff = busy & ~busy_ignore & ~timeout;
`else
    timeout  = 1'b0;
    busy_eff = busy;
`endif

    // cnt==0 is the first RUN cycle, where busy is expected high; a low
    // busy there is an error, not a completion.
    done       = in_run & ((~busy & (cnt != '0)) | timeout);
    run_active = in_run & ~done;

    err_set = (in_run & (cnt == '0) & ~busy) | (in_run & md_vld_e) | timeout;

    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    md_done = done;
    md_err  = md_err_r;
  end

  md_hazard_unit u_hazard (
    .MDOp_D     (MDOp_D),
    .MTOp_D     (MTOp_D),
    .MFOp_D     (MFOp_D),
    .start      (start),
    .run_active (run_active),
    .busy       (busy_eff),
    .Stall_MD   (Stall_MD)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      md_err_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      md_err_r <= md_err_r | err_set;
      if (state != ST_RUN) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef MD_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_ignore <= 1'b0;
    end else if (timeout) begin
      busy_ignore <= 1'b1;
    end else if (!busy) begin
      busy_ignore <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue and hazard controller for the pipeline's multiply/divide unit.
- Sits between decode (D) / execute (E) and the mult/div unit.
- Generates the unit's start pulse and operation codes from the E-stage instruction, suppresses them on flush, and tracks the operation in flight with an FSM.
- Stalls D while an instruction there would conflict with an operation in flight.

Parameters:
- MD_LAT, 5: nominal unit latency in cycles; busy is high for this many cycles after start.
- TIMEOUT_SLACK, 4: extra cycles tolerated beyond MD_LAT before a timeout (only with MD_TIMEOUT_EN).

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- MDOp_E  in  3  E-stage mult/div class: 0 none, 1 mult, 2 multu, 3 div, 4 divu; 5-7 treated as 0.
- MTOp_E  in  2  E-stage move-to: 01 mthi, 10 mtlo, else none.
- MDOp_D  in  3  D-stage mult/div class, same encoding.
- MTOp_D  in  2  D-stage move-to class.
- MFOp_D  in  2  D-stage move-from: 01 mfhi, 10 mflo.
- Flush  in  1  E-stage instruction killed this cycle.
- busy  in  1  busy flag from the mult/div unit.
- start  out  1  one-cycle start pulse to the unit.
- MDOp  out  3  operation code to the unit; 0 when start is low.
- MTOp  out  2  move-to code to the unit; 0 when suppressed.
- Stall_MD  out  1  stall request for D.
- md_done  out  1  one-cycle pulse; Hi/Lo are final.
- md_err  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, Clk edge with Reset=1):
  - state=IDLE, cnt=0, md_err=0.
  - All outputs 0 in the following cycle.
  - Reset mid-operation abandons tracking; the unit shares Reset.
- States: IDLE, RUN (2-bit encoding, IDLE=0).
- start (combinational) = (state==IDLE) & MDOp_E in 1..4 & !Flush. MDOp = start ? MDOp_E : 0.
- MTOp (combinational) = (state==IDLE & !Flush & MDOp_E==0) ? MTOp_E : 0. A valid MDOp_E takes priority; a simultaneous nonzero MTOp_E is dropped.
- IDLE -> RUN when start; cnt<=0.
- RUN:
  - cnt increments each cycle, saturating at 15.
  - First RUN cycle: busy must be 1. If busy=0, set md_err.
  - busy=0 with cnt>=1: go to IDLE and pulse md_done in that same cycle. The unit has already latched Hi/Lo on that edge.
- MD-class D instruction: MDOp_D in 1..4, MTOp_D!=0, or MFOp_D!=0.
- Stall_MD = MD-class D & (start | state==RUN | busy).
  - The start cycle stalls, because busy rises only one edge after start.
  - Stall drops in the md_done cycle. An mfhi/mflo released then reaches E one cycle later and reads the final Hi/Lo.
- Flush:
  - Affects only the E-stage issue (start/MTOp suppressed).
  - Never aborts RUN; an issued op completes.
  - Stall_MD is unaffected.
- An MD op in E while state==RUN (illegal, since stall should prevent it): no start, set md_err.
- Non-MD D instructions never stall.

Optional Feature:
- Macro: MD_TIMEOUT_EN.
- Defined: in RUN, if cnt reaches MD_LAT+TIMEOUT_SLACK with busy still 1:
  - set md_err;
  - force state=IDLE;
  - pulse md_done;
  - release the stall so the pipeline cannot hang.
- Undefined: no timeout; RUN waits indefinitely for busy=0; TIMEOUT_SLACK unused.

Decomposition:
- Shared package (md_pkg):
  - MDOp encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - MTOp/MFOp encodings (MT_HI, MT_LO, MF_HI, MF_LO);
  - FSM state constants;
  - default MD_LAT.
- One natural sub-module, md_hazard_unit: the purely combinational MD-class decode and Stall_MD equation. The FSM and counter stay in the top level.

Test Plan:
- mult in E (MDOp_E=1), unit with 5-cycle busy:
  - start=1 and MDOp=1 for exactly one cycle;
  - RUN for 5 cycles;
  - md_done in cycle 6;
  - md_err=0.
- mult in E, mflo in D the same cycle:
  - Stall_MD=1 from the start cycle through the last busy cycle;
  - Stall_MD=0 in the md_done cycle;
  - mflo reads the product, e.g. 3*-2 yields Lo=0xFFFFFFFA.
- div in E with Flush=1: start=0, MDOp=0, state stays IDLE, no stall for a following mfhi in D.
- mthi in E (MTOp_E=01), IDLE: MTOp=01 passes through. The same with Flush=1: MTOp=00.
- Reset=1 asserted in the 3rd RUN cycle: next cycle state=IDLE, Stall_MD=0, md_done=0, md_err=0.
- With MD_TIMEOUT_EN, busy held high:
  - after MD_LAT+TIMEOUT_SLACK=9 RUN cycles, md_err=1 and md_done pulses;
  - state returns to IDLE and Stall_MD drops.
- Without the macro, RUN persists.
